fetch_queue: RTL

Parametrised successor to the single-register IF stage of the 16-bit pipelined core. It replaces the fixed 16-bit PC, adder and IF/ID flop with a decoupled fetch unit. The unit owns the PC, issues requests to a synchronous (1-cycle latency) instruction memory, and buffers returned instructions with their PC+1 in a DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready handshake, and branch/jump redirects flush the queue, including any in-flight fetch.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and queue-entry layout for the decoupled fetch unit.
package fetch_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
  localparam int ENTRY_W_DEF = INSTR_W_DEF + ADDR_W_DEF;

  // Queue entry as stored: instruction in the upper bits, its PC+1 below.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pcPlus1;
  } fetchEntry_t;

  function automatic int entryWidth(input int instrW, input int addrW);
    return instrW + addrW;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous prefetch FIFO: DEPTH x WIDTH, push/pop/clear, head masked to 0 when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             pushEn;
  logic             popEn;

  assign valid  = (countReg != '0);
  assign pushEn = push && !clear && (countReg != CNT_W'(DEPTH));
  assign popEn  = pop && !clear && valid;

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtrReg] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (clear) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popEn)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({pushEn, popEn})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  // Masking keeps the head outputs at zero after reset and whenever the queue is empty.
  assign head  = valid ? mem[rdPtrReg] : '0;
  assign count = countReg;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch unit: owns the PC, issues 1-cycle imem requests, buffers results in a prefetch queue.
// Optional request/flush statistics are built when FETCH_STATS_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pcplus1,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              flush_cnt
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = entryWidth(INSTR_W, ADDR_W);

  logic [ADDR_W-1:0]  pcReg;
  logic               inflightReg;
  logic [ADDR_W-1:0]  inflightPcPlus1Reg;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               pushEn;
  logic               popEn;
  logic [ENTRY_W-1:0] headEntry;

  // Slots are reserved at issue time, so a returning fetch always finds room.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflightReg);
  assign issue     = !reset && !redirect_valid && !halt && (occupancy < (CNT_W+1)'(DEPTH));
  assign pushEn    = inflightReg && !redirect_valid;
  assign popEn     = instr_valid && instr_ready && !redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = pcReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg              <= RESET_PC;
      inflightReg        <= 1'b0;
      inflightPcPlus1Reg <= '0;
    end else begin
      inflightReg <= issue;
      if (issue) inflightPcPlus1Reg <= pcReg + ADDR_W'(1);
      if (redirect_valid)  pcReg <= redirect_pc;
      else if (issue)      pcReg <= pcReg + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushEn),
    .pushData ({imem_rdata, inflightPcPlus1Reg}),
    .pop      (popEn),
    .clear    (redirect_valid),
    .count    (count),
    .head     (headEntry),
    .valid    (instr_valid)
  );

  assign {instr, instr_pcplus1} = headEntry;

`ifdef FETCH_STATS_EN
  logic [31:0] fetchCntReg;
  logic [31:0] flushCntReg;
  logic        discard;

  // A fetch still in flight when the redirect lands is counted as flushed too.
  assign discard = redirect_valid && inflightReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (issue) fetchCntReg <= fetchCntReg + 32'd1;
      if (redirect_valid) flushCntReg <= flushCntReg + 32'(count) + 32'(discard);
    end
  end

  assign fetch_cnt = fetchCntReg;
  assign flush_cnt = flushCntReg;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
